// File: rtl/net_arb_pkg.sv
// Shared types and default sizing for the wired-net drive arbiter.
// Also holds the modular index helper used by the round-robin picker.
package net_arb_pkg;

  localparam int DEF_N_REQ    = 4;
  localparam int DEF_W        = 4;
  localparam int DEF_MAX_HOLD = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } arb_state_t;

  // Index reached by stepping 'offset' places upward from 'base', wrapping at n.
  function automatic int rr_index(input int base, input int offset, input int n);
    return (base + offset) % n;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin winner selection: first requester set when
// scanning upward from last_owner+1, so the previous owner is considered last.
module rr_picker
  import net_arb_pkg::*;
#(
  parameter int  N_REQ = DEF_N_REQ,
  localparam int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    last_owner,
  output logic             valid,
  output logic [IW-1:0]    winner
);

  logic [IW-1:0]    cand_idx [N_REQ];
  logic [N_REQ-1:0] cand_req;

  // Candidate gi is the requester gi+1 places after the last owner.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
    assign cand_idx[gi] = IW'(rr_index(int'(last_owner), gi + 1, N_REQ));
    assign cand_req[gi] = req[cand_idx[gi]];
  end

  // Scan from the far end so the nearest candidate is the one that sticks.
  always_comb begin
    valid  = 1'b0;
    winner = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (cand_req[k]) begin
        valid  = 1'b1;
        winner = cand_idx[k];
      end
    end
  end

endmodule

// File: rtl/net_drive_arbiter.sv
// Tenure-based arbiter for a shared tri-state net: one owner at a time,
// bounded hold, and a mandatory one-cycle dead turn between tenures.
module net_drive_arbiter
  import net_arb_pkg::*;
#(
  parameter int  N_REQ    = DEF_N_REQ,
  parameter int  W        = DEF_W,
  parameter int  MAX_HOLD = DEF_MAX_HOLD,
  localparam int IW       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ-1:0]   done,
  input  logic [N_REQ*W-1:0] wdata,
  output logic [N_REQ-1:0]   grant,
  output logic [IW-1:0]      owner_id,
  output logic               bus_oe,
  output logic [W-1:0]       bus_data,
  output logic [7:0]         hold_cnt
);

  arb_state_t       state_reg, state_next;
  logic [N_REQ-1:0] grant_reg, grant_next;
  logic [IW-1:0]    owner_reg, owner_next;
  logic [IW-1:0]    last_reg, last_next;
  logic [7:0]       hold_reg, hold_next;

  logic             pick_valid;
  logic [IW-1:0]    pick_winner;
  logic             owner_release;

  rr_picker #(.N_REQ(N_REQ)) u_picker (
    .req        (req),
    .last_owner (last_reg),
    .valid      (pick_valid),
    .winner     (pick_winner)
  );

  // Only the current owner's controls matter; other requesters cannot cut a tenure short.
  assign owner_release = done[owner_reg] | ~req[owner_reg]
                       | (hold_reg == 8'(MAX_HOLD - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      grant_reg <= '0;
      owner_reg <= '0;
      last_reg  <= IW'(N_REQ - 1);
      hold_reg  <= '0;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      owner_reg <= owner_next;
      last_reg  <= last_next;
      hold_reg  <= hold_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    owner_next = owner_reg;
    last_next  = last_reg;
    hold_next  = hold_reg;

    case (state_reg)
      // IDLE and TURN both arbitrate; TURN has already moved last_owner on.
      IDLE, TURN: begin
        hold_next = '0;
        if (pick_valid) begin
          state_next = GRANT;
          grant_next = N_REQ'(1) << pick_winner;
          owner_next = pick_winner;
        end else begin
          state_next = IDLE;
          grant_next = '0;
          owner_next = '0;
        end
      end

      GRANT: begin
        if (owner_release) begin
          state_next = TURN;
          grant_next = '0;
          owner_next = '0;
          last_next  = owner_reg;
          hold_next  = '0;
        end else begin
          hold_next = hold_reg + 8'd1;
        end
      end

      default: begin
        state_next = IDLE;
        grant_next = '0;
        owner_next = '0;
        hold_next  = '0;
      end
    endcase
  end

  assign grant    = grant_reg;
  assign owner_id = owner_reg;
  assign hold_cnt = hold_reg;
  assign bus_oe   = |grant_reg;

  // Single driver for the net; released to high impedance whenever nobody owns it.
  assign bus_data = bus_oe ? wdata[owner_reg*W +: W] : {W{1'bz}};

endmodule
